// File: rtl/fpall_pkg.sv
// Shared types and the FP32 add/sub datapath used by the fpall wrapper.
package fpall_pkg;

  typedef enum logic [1:0] {
    FMT_FP32 = 2'd0,
    FMT_FP16 = 2'd1
  } fp_fmt_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } fp_op_e;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // FP32 a +/- b, round-to-nearest-even; subnormal inputs and results flush to zero.
  function automatic logic [31:0] fp32_addsub(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sub);
    logic              s_l, s_s;
    logic [30:0]       mag_l, mag_s;
    logic [7:0]        el, es, d;
    logic [23:0]       ml, ms;
    logic [26:0]       big, sml, ext, mask, mant;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic              found, rnd;
    logic [24:0]       m25;
    logic signed [9:0] e;

    // Order operands by magnitude so the aligned difference is never negative.
    if (b[30:0] > a[30:0]) begin
      s_l = b[31] ^ sub; mag_l = b[30:0];
      s_s = a[31];       mag_s = a[30:0];
    end else begin
      s_l = a[31];       mag_l = a[30:0];
      s_s = b[31] ^ sub; mag_s = b[30:0];
    end
    el = mag_l[30:23];
    es = mag_s[30:23];

    // Larger operand Inf/NaN; a NaN or Inf-Inf yields the canonical quiet NaN.
    if (el == 8'hFF) begin
      if ((mag_l[22:0] != 23'd0) ||
          ((es == 8'hFF) && ((mag_s[22:0] != 23'd0) || (s_l != s_s))))
        return FP32_QNAN;
      return {s_l, 8'hFF, 23'd0};
    end
    if (el == 8'd0)
      return {s_l & s_s, 31'd0};

    ml  = {1'b1, mag_l[22:0]};
    ms  = (es == 8'd0) ? 24'd0 : {1'b1, mag_s[22:0]};
    d   = el - es;
    big = {ml, 3'b000};

    // Align the smaller operand, folding shifted-out bits into the sticky bit.
    if (ms == 24'd0) begin
      sml = '0;
    end else if (d >= 8'd27) begin
      sml = 27'd1;
    end else begin
      ext  = {ms, 3'b000};
      mask = (27'd1 << d) - 27'd1;
      sml  = (ext >> d) | {26'd0, |(ext & mask)};
    end

    sum = (s_l == s_s) ? ({1'b0, big} + {1'b0, sml}) : ({1'b0, big} - {1'b0, sml});
    if (sum == 28'd0)
      return 32'd0;

    e = $signed({2'b00, el});
    if (sum[27]) begin
      mant = sum[27:1] | {26'd0, sum[0]};
      e    = e + 10'sd1;
    end else begin
      lz    = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < 27; k++) begin
        if (!found && sum[26-k]) begin
          lz    = 5'(k);
          found = 1'b1;
        end
      end
      mant = sum[26:0] << lz;
      e    = e - $signed({5'd0, lz});
    end
    if (e <= 10'sd0)
      return {s_l, 31'd0};

    // mant: [26] hidden, [25:3] fraction, [2] guard, [1] round, [0] sticky.
    rnd = mant[2] & (mant[3] | mant[1] | mant[0]);
    m25 = {1'b0, mant[26:3]} + {24'd0, rnd};
    if (m25[24]) begin
      m25 = m25 >> 1;
      e   = e + 10'sd1;
    end
    if (e >= 10'sd255)
      return {s_l, 8'hFF, 23'd0};
    return {s_l, e[7:0], m25[22:0]};
  endfunction

endpackage

// File: rtl/fpall_shared_logic_wrapper.sv
// Fixed-latency, fully pipelined FP add/sub unit: R is valid LAT posedges after inputs.
module fpall_shared_logic_wrapper
  import fpall_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic        clk,
  input  fp_fmt_e     fmt_in,
  input  fp_op_e      opcode_in,
  input  logic [31:0] X,
  input  logic [31:0] Y,
  output logic [31:0] R
);

  logic [31:0] w_res;
  logic [31:0] r_pipe [0:LAT-1];

  // Only FP32 is implemented; other formats return the canonical NaN.
  always_comb begin
    w_res = FP32_QNAN;
    if (fmt_in == FMT_FP32)
      w_res = fp32_addsub(X, Y, opcode_in == OP_SUB);
  end

  // Result delay line; no reset, validity is tracked by the caller.
  always_ff @(posedge clk) begin
    r_pipe[0] <= w_res;
    for (int unsigned i = 1; i < LAT; i++)
      r_pipe[i] <= r_pipe[i-1];
  end

  assign R = r_pipe[LAT-1];

endmodule

// File: rtl/fpall_req_resp.sv
// Valid/ready request-response shell around the fpall wrapper with a credit-managed
// response FIFO; results leave in acceptance order.
module fpall_req_resp
  import fpall_pkg::*;
#(
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  fp_fmt_e                      req_fmt,
  input  fp_op_e                       req_op,
  input  logic [31:0]                  req_x,
  input  logic [31:0]                  req_y,
  input  logic [TAG_W-1:0]             req_tag,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [31:0]                  resp_r,
  output logic [TAG_W-1:0]             resp_tag,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  if ((LAT < 1) || (DEPTH < LAT + 2)) begin : g_bad_params
    $error("fpall_req_resp: need LAT >= 1 and DEPTH >= LAT+2");
  end

  logic              w_accept, w_push, w_pop;
  logic [31:0]       w_r;
  logic [CNT_W-1:0]  w_inflight, w_occ;

  fp_fmt_e           r_fmt;
  fp_op_e            r_op;
  logic [31:0]       r_x, r_y;
  logic [LAT:0]      r_vld;
  logic [TAG_W-1:0]  r_tag [0:LAT];

  logic [31:0]       r_mem_r   [0:DEPTH-1];
  logic [TAG_W-1:0]  r_mem_tag [0:DEPTH-1];
  logic [PTR_W-1:0]  r_wr, r_rd;
  logic [CNT_W-1:0]  r_count;

  function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit: every accepted op already owns a FIFO slot, so overflow cannot occur.
  always_comb begin
    w_inflight = '0;
    for (int unsigned i = 0; i <= LAT; i++)
      w_inflight = w_inflight + CNT_W'(r_vld[i]);
    w_occ      = w_inflight + r_count;
    req_ready  = (w_occ < CNT_W'(DEPTH));
    occupancy  = w_occ;
    w_accept   = req_valid & req_ready;
    w_push     = r_vld[LAT];
    resp_valid = (r_count != '0);
    w_pop      = resp_valid & resp_ready;
    resp_r     = resp_valid ? r_mem_r[r_rd]   : '0;
    resp_tag   = resp_valid ? r_mem_tag[r_rd] : '0;
  end

  // Issue register (holds without accept) and tag chain; stage 0 tag is the issue tag.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_fmt    <= req_fmt;
      r_op     <= req_op;
      r_x      <= req_x;
      r_y      <= req_y;
      r_tag[0] <= req_tag;
    end
    for (int unsigned i = 1; i <= LAT; i++)
      r_tag[i] <= r_tag[i-1];
  end

  // Valid chain: stage LAT lines up with a valid wrapper result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_vld <= '0;
    else
      r_vld <= {r_vld[LAT-1:0], w_accept};
  end

  fpall_shared_logic_wrapper #(
    .LAT (LAT)
  ) u_wrap (
    .clk       (clk),
    .fmt_in    (r_fmt),
    .opcode_in (r_op),
    .X         (r_x),
    .Y         (r_y),
    .R         (w_r)
  );

  // FIFO storage; contents beyond the count are don't-care.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_r[r_wr]   <= w_r;
      r_mem_tag[r_wr] <= r_tag[LAT];
    end
  end

  // FIFO pointers and count; push+pop together leaves the count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wr <= f_next(r_wr);
      if (w_pop)
        r_rd <= f_next(r_rd);
      if (w_push && !w_pop)
        r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push)
        r_count <= r_count - CNT_W'(1);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_push && !w_pop && (r_count == CNT_W'(DEPTH))));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(w_pop && (r_count == '0)));

endmodule

// File: tb/tb_fpall_req_resp.sv
module tb_fpall_req_resp;
  import fpall_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  fp_fmt_e     req_fmt;
  fp_op_e      req_op;
  logic [31:0] req_x, req_y;
  logic [3:0]  req_tag;
  logic        resp_ready;

  logic        req_ready_a, resp_valid_a;
  logic [31:0] resp_r_a;
  logic [3:0]  resp_tag_a;
  logic [2:0]  occ_a;

  logic        req_ready_b, resp_valid_b;
  logic [31:0] resp_r_b;
  logic [3:0]  resp_tag_b;
  logic [2:0]  occ_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fpall_req_resp u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_a),
    .req_fmt(req_fmt), .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
    .resp_valid(resp_valid_a), .resp_ready(resp_ready), .resp_r(resp_r_a),
    .resp_tag(resp_tag_a), .occupancy(occ_a)
  );

  // Deeper instance: with LAT=2 one result per cycle needs DEPTH >= 5.
  fpall_req_resp #(.DEPTH(5)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_b),
    .req_fmt(req_fmt), .req_op(req_op), .req_x(req_x), .req_y(req_y), .req_tag(req_tag),
    .resp_valid(resp_valid_b), .resp_ready(resp_ready), .resp_r(resp_r_b),
    .resp_tag(resp_tag_b), .occupancy(occ_b)
  );

  typedef struct {
    fp_fmt_e     fmt;
    fp_op_e      op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] r;
  } vec_t;

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_fmt = FMT_FP32; req_op = OP_ADD;
    req_x = '0; req_y = '0; req_tag = '0; resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (resp_valid_a !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid_a); end
    total++; if (req_ready_a !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready_a); end
    total++; if (occ_a !== 3'd0) begin bad++; $display("FAIL reset_occupancy got=%0d want=0", occ_a); end
    total++; if (resp_r_a !== 32'd0) begin bad++; $display("FAIL reset_resp_r got=%h want=0", resp_r_a); end
    total++; if (resp_tag_a !== 4'd0) begin bad++; $display("FAIL reset_resp_tag got=%h want=0", resp_tag_a); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_add();
    req_valid = 1'b1; req_fmt = FMT_FP32; req_op = OP_ADD;
    req_x = 32'h3F80_0000; req_y = 32'h3F80_0000; req_tag = 4'd5; resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (resp_valid_a !== (k == 3)) begin
        bad++; $display("FAIL latency_k%0d resp_valid got=%b want=%b", k, resp_valid_a, (k == 3));
      end
      if (k != 3) @(posedge clk);
    end
    total++; if (resp_r_a !== 32'h4000_0000) begin bad++; $display("FAIL single_add_r got=%h want=40000000", resp_r_a); end
    total++; if (resp_tag_a !== 4'd5) begin bad++; $display("FAIL single_add_tag got=%h want=5", resp_tag_a); end
    total++; if (occ_a !== 3'd1) begin bad++; $display("FAIL single_add_occ got=%0d want=1", occ_a); end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    total++; if (resp_valid_a !== 1'b0) begin bad++; $display("FAIL single_pop_valid got=%b want=0", resp_valid_a); end
    total++; if (occ_a !== 3'd0) begin bad++; $display("FAIL single_pop_occ got=%0d want=0", occ_a); end
    @(posedge clk); #1;
  endtask

  task automatic test_vectors();
    vec_t v [8];
    int   n;
    v[0] = '{FMT_FP32, OP_ADD, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000};
    v[1] = '{FMT_FP32, OP_ADD, 32'h3F80_0000, 32'hBF80_0001, 32'hB400_0000};
    v[2] = '{FMT_FP32, OP_SUB, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000};
    v[3] = '{FMT_FP32, OP_ADD, 32'h4040_0000, 32'h3F00_0000, 32'h4060_0000};
    v[4] = '{FMT_FP32, OP_ADD, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
    v[5] = '{FMT_FP32, OP_ADD, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002};
    v[6] = '{FMT_FP32, OP_ADD, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000};
    v[7] = '{FMT_FP16, OP_ADD, 32'h0000_3C00, 32'h0000_3C00, 32'h7FC0_0000};
    resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_fmt = v[i].fmt; req_op = v[i].op;
      req_x = v[i].x; req_y = v[i].y; req_tag = 4'(i + 2);
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!resp_valid_a && n < 10) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (!resp_valid_a) begin
        bad++; $display("FAIL vec%0d_timeout got=no_resp want=resp", i);
      end else begin
        total++; if (resp_r_a !== v[i].r) begin bad++; $display("FAIL vec%0d_r got=%h want=%h", i, resp_r_a, v[i].r); end
        total++; if (resp_tag_a !== 4'(i + 2)) begin bad++; $display("FAIL vec%0d_tag got=%h want=%h", i, resp_tag_a, 4'(i + 2)); end
        total++; if (n !== 3) begin bad++; $display("FAIL vec%0d_latency got=%0d want=3", i, n); end
      end
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] q [$];
    logic [3:0] exp_tag;
    int  sent, got, n;
    logic acc;
    do_reset();
    resp_ready = 1'b0; req_valid = 1'b1; req_fmt = FMT_FP32; req_op = OP_ADD;
    req_x = 32'h3F80_0000; req_y = 32'h4000_0000; req_tag = 4'd0;
    sent = 0; got = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++;
      if (req_ready_a !== (sent < 4)) begin
        bad++; $display("FAIL bp_ready_c%0d got=%b want=%b", c, req_ready_a, (sent < 4));
      end
      acc = req_ready_a;
      if (acc) q.push_back(req_tag);
      @(posedge clk); #1;
      if (acc) begin sent++; req_tag = 4'(sent); end
    end
    @(negedge clk);
    total++; if (sent !== 4) begin bad++; $display("FAIL bp_accepted got=%0d want=4", sent); end
    total++; if (occ_a !== 3'd4) begin bad++; $display("FAIL bp_occ got=%0d want=4", occ_a); end
    total++; if (resp_valid_a !== 1'b1) begin bad++; $display("FAIL bp_resp_valid got=%b want=1", resp_valid_a); end
    resp_ready = 1'b1;
    total++; if (req_ready_a !== 1'b0) begin bad++; $display("FAIL bp_ready_during_pop got=%b want=0", req_ready_a); end
    n = 0;
    while (got < 6 && n < 40) begin
      if (resp_valid_a) begin
        exp_tag = q.pop_front();
        total++;
        if (resp_tag_a !== exp_tag) begin bad++; $display("FAIL bp_order%0d got=%h want=%h", got, resp_tag_a, exp_tag); end
        got++;
      end
      acc = req_valid && req_ready_a;
      if (acc) q.push_back(req_tag);
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent == 6) req_valid = 1'b0; else req_tag = 4'(sent);
      end
      @(negedge clk);
      n++;
    end
    total++; if (got !== 6) begin bad++; $display("FAIL bp_returned got=%0d want=6", got); end
    total++; if (sent !== 6) begin bad++; $display("FAIL bp_total_accepted got=%0d want=6", sent); end
    req_valid = 1'b0; resp_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    do_reset();
    resp_ready = 1'b1; req_valid = 1'b1; req_fmt = FMT_FP32; req_op = OP_ADD;
    req_x = 32'h3F80_0000; req_y = 32'h3F80_0000; req_tag = 4'd0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 8) begin
        total++; if (req_ready_b !== 1'b1) begin bad++; $display("FAIL b2b_ready_c%0d got=%b want=1", c, req_ready_b); end
      end
      exp_v = (c >= 4) && (c < 12);
      total++; if (resp_valid_b !== exp_v) begin bad++; $display("FAIL b2b_valid_c%0d got=%b want=%b", c, resp_valid_b, exp_v); end
      if (exp_v) begin
        total++; if (resp_tag_b !== 4'(c - 4)) begin bad++; $display("FAIL b2b_tag_c%0d got=%h want=%h", c, resp_tag_b, 4'(c - 4)); end
        total++; if (resp_r_b !== 32'h4000_0000) begin bad++; $display("FAIL b2b_r_c%0d got=%h want=40000000", c, resp_r_b); end
      end
      @(posedge clk); #1;
      if (c < 7) req_tag = 4'(c + 1); else req_valid = 1'b0;
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_reset();
    resp_ready = 1'b0; req_valid = 1'b1; req_fmt = FMT_FP32; req_op = OP_ADD;
    req_x = 32'h3F80_0000; req_y = 32'h3F80_0000;
    for (int i = 0; i < 4; i++) begin
      req_tag = 4'(8 + i);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (occ_b !== 3'd4) begin bad++; $display("FAIL full_occ_before got=%0d want=4", occ_b); end
    @(posedge clk); #1;
    req_valid = 1'b1; req_tag = 4'd12;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    total++; if (occ_b !== 3'd5) begin bad++; $display("FAIL full_occ_peak got=%0d want=5", occ_b); end
    total++; if (req_ready_b !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", req_ready_b); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    total++; if (occ_b !== 3'd4) begin bad++; $display("FAIL full_occ_after got=%0d want=4", occ_b); end
    total++; if (resp_tag_b !== 4'd9) begin bad++; $display("FAIL full_head_tag got=%h want=9", resp_tag_b); end
    resp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      total++; if (resp_tag_b !== 4'(9 + k)) begin bad++; $display("FAIL full_drain%0d got=%h want=%h", k, resp_tag_b, 4'(9 + k)); end
      @(posedge clk);
      @(negedge clk);
    end
    total++; if (resp_valid_b !== 1'b0) begin bad++; $display("FAIL full_drained_valid got=%b want=0", resp_valid_b); end
    total++; if (occ_b !== 3'd0) begin bad++; $display("FAIL full_drained_occ got=%0d want=0", occ_b); end
    resp_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop();
    logic stale;
    int   n;
    do_reset();
    resp_ready = 1'b0; req_valid = 1'b1; req_fmt = FMT_FP32; req_op = OP_ADD;
    req_x = 32'h3F80_0000; req_y = 32'h3F80_0000;
    for (int i = 0; i < 3; i++) begin
      req_tag = 4'(i + 1);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (resp_valid_a !== 1'b1) begin bad++; $display("FAIL midrst_pre_valid got=%b want=1", resp_valid_a); end
    total++; if (occ_a !== 3'd3) begin bad++; $display("FAIL midrst_pre_occ got=%0d want=3", occ_a); end
    rst_n = 1'b0;
    #1;
    total++; if (resp_valid_a !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b want=0", resp_valid_a); end
    total++; if (occ_a !== 3'd0) begin bad++; $display("FAIL midrst_occ got=%0d want=0", occ_a); end
    total++; if (req_ready_a !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", req_ready_a); end
    total++; if (resp_r_a !== 32'd0) begin bad++; $display("FAIL midrst_r got=%h want=0", resp_r_a); end
    @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid_a) stale = 1'b1;
    end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL midrst_stale got=%b want=0", stale); end
    @(posedge clk); #1;
    req_valid = 1'b1; req_x = 32'h4040_0000; req_y = 32'h3F00_0000; req_tag = 4'd9;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!resp_valid_a && n < 10) begin
      @(negedge clk);
      n++;
    end
    total++; if (n !== 3) begin bad++; $display("FAIL midrst_next_latency got=%0d want=3", n); end
    total++; if (resp_r_a !== 32'h4060_0000) begin bad++; $display("FAIL midrst_next_r got=%h want=40600000", resp_r_a); end
    total++; if (resp_tag_a !== 4'd9) begin bad++; $display("FAIL midrst_next_tag got=%h want=9", resp_tag_a); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_full_push_pop();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
